// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and execute.
// Splits the instruction into fields, extends the immediate, derives class and
// writeback controls, and stalls one cycle on load-use hazards.
// Optional: define DECODE_ILLEGAL_TRAP_EN to add the registered 'illegal' flag.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [5:0]            op,
  output logic [5:0]            func,
  output logic [REG_ADDR_W-1:0] reg_s,
  output logic [REG_ADDR_W-1:0] reg_t,
  output logic [REG_ADDR_W-1:0] reg_d,
  output logic [4:0]            shamt,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [25:0]           jump_addr,
  output logic                  is_rtype,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  is_branch,
  output logic                  is_jump,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] wb_reg,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                  illegal,
`endif
  output logic                  hazard
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [5:0]            op;
    logic [5:0]            func;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] imm;
    logic [25:0]           jaddr;
    logic                  rtype;
    logic                  load;
    logic                  store;
    logic                  branch;
    logic                  jump;
    logic                  rw;
    logic [REG_ADDR_W-1:0] wb;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
  } bundle_t;

  bundle_t dec;        // decode of the instruction currently offered
  bundle_t bundle_d, bundle_q;
  logic    valid_d, valid_q;
  logic    accept;
  logic    hazard_c;
  logic    use_s, use_t;

  logic [5:0]  in_op, in_func;
  logic [31:0] lui_w;
  logic        wb_valid;
  logic [REG_ADDR_W-1:0] wb_cand;

  assign in_op   = in_instr[31:26];
  assign in_func = in_instr[5:0];
  assign lui_w   = {in_instr[15:0], 16'h0000};

  // Combinational decode of the incoming instruction into a bundle.
  always_comb begin
    dec        = '0;
    wb_valid   = 1'b0;
    wb_cand    = '0;
    dec.pc     = in_pc;
    dec.op     = in_op;
    dec.func   = in_func;
    dec.rs     = REG_ADDR_W'(in_instr[25:21]);
    dec.rt     = REG_ADDR_W'(in_instr[20:16]);
    dec.rd     = REG_ADDR_W'(in_instr[15:11]);
    dec.shamt  = in_instr[10:6];
    dec.jaddr  = in_instr[25:0];
    dec.rtype  = (in_op == 6'h00);
    dec.load   = in_op inside {[6'h20:6'h25]};
    dec.store  = in_op inside {[6'h28:6'h2B]};
    dec.branch = in_op inside {6'h01, [6'h04:6'h07]};
    dec.jump   = (in_op inside {6'h02, 6'h03}) ||
                 (dec.rtype && (in_func inside {6'h08, 6'h09}));

    if (in_op inside {[6'h0C:6'h0E]}) begin
      dec.imm       = '0;
      dec.imm[15:0] = in_instr[15:0];
    end else if (in_op == 6'h0F) begin
      dec.imm = DATA_WIDTH'(lui_w);
    end else begin
      dec.imm       = {DATA_WIDTH{in_instr[15]}};
      dec.imm[15:0] = in_instr[15:0];
    end

    if (dec.rtype && (in_func != 6'h08)) begin
      wb_valid = 1'b1;
      wb_cand  = dec.rd;
    end else if ((in_op inside {[6'h08:6'h0F]}) || dec.load) begin
      wb_valid = 1'b1;
      wb_cand  = dec.rt;
    end else if (in_op == 6'h03) begin
      wb_valid = 1'b1;
      wb_cand  = REG_ADDR_W'(5'd31);
    end
    dec.rw = wb_valid && (wb_cand != '0);
    dec.wb = dec.rw ? wb_cand : '0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    if (dec.rtype)
      dec.illegal = !(in_func inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                      6'h08, 6'h09, 6'h0C, 6'h0D,
                                      [6'h10:6'h13], [6'h18:6'h1B],
                                      [6'h20:6'h27], 6'h2A, 6'h2B});
    else
      dec.illegal = !(in_op inside {6'h01, [6'h02:6'h0F],
                                    [6'h20:6'h25], [6'h28:6'h2B]});
    if (dec.illegal) begin
      dec.rw    = 1'b0;
      dec.wb    = '0;
      dec.load  = 1'b0;
      dec.store = 1'b0;
    end
`endif
  end

  // Load-use hazard: held load writes a register the offered instruction reads.
  always_comb begin
    use_s    = !(in_op inside {6'h02, 6'h03});
    use_t    = (in_op == 6'h00) || (in_op inside {[6'h28:6'h2B]}) ||
               (in_op inside {6'h04, 6'h05});
    hazard_c = valid_q && bundle_q.load && bundle_q.rw && in_valid &&
               (bundle_q.wb != '0) &&
               ((use_s && (dec.rs == bundle_q.wb)) ||
                (use_t && (dec.rt == bundle_q.wb)));
  end

  assign hazard   = hazard_c;
  // Flush drains whatever fetch offers, so it overrides backpressure and stalls.
  assign in_ready = flush || ((!valid_q || out_ready) && !hazard_c);
  assign accept   = in_valid && in_ready;

  // Next-state for the output register: flush, then accept, then drain, else hold.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = bundle_q.pc;
  assign op        = bundle_q.op;
  assign func      = bundle_q.func;
  assign reg_s     = bundle_q.rs;
  assign reg_t     = bundle_q.rt;
  assign reg_d     = bundle_q.rd;
  assign shamt     = bundle_q.shamt;
  assign imm_ext   = bundle_q.imm;
  assign jump_addr = bundle_q.jaddr;
  assign is_rtype  = bundle_q.rtype;
  assign is_load   = bundle_q.load;
  assign is_store  = bundle_q.store;
  assign is_branch = bundle_q.branch;
  assign is_jump   = bundle_q.jump;
  assign reg_write = bundle_q.rw;
  assign wb_reg    = bundle_q.wb;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal   = bundle_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the decode rules and the one-entry stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm_ext;
  logic [5:0]  op, func;
  logic [4:0]  reg_s, reg_t, reg_d, shamt, wb_reg;
  logic [25:0] jump_addr;
  logic        is_rtype, is_load, is_store, is_branch, is_jump, reg_write, hazard;

  int vectors = 0;
  int miscompares = 0;

  // model state: whether the stage holds a bundle, and what it was built from
  bit          m_valid;
  logic [31:0] m_instr, m_pc;
  logic        last_hazard;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(32), .PC_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op(op), .func(func), .reg_s(reg_s), .reg_t(reg_t), .reg_d(reg_d),
    .shamt(shamt), .imm_ext(imm_ext), .jump_addr(jump_addr),
    .is_rtype(is_rtype), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jump(is_jump), .reg_write(reg_write),
    .wb_reg(wb_reg), .hazard(hazard)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rt, ld, st, br, jp, rw;
    logic [4:0]  wb;
    logic [31:0] imm;
  } ref_t;

  // Decode rules stated directly from the opcode/function tables.
  function automatic ref_t ref_dec(input logic [31:0] ins);
    ref_t r;
    int o, f;
    int dst;
    o = int'(ins[31:26]);
    f = int'(ins[5:0]);
    r.rt = (o == 0);
    r.ld = (o >= 32 && o <= 37);
    r.st = (o >= 40 && o <= 43);
    r.br = (o == 1) || (o >= 4 && o <= 7);
    r.jp = (o == 2) || (o == 3) || (o == 0 && (f == 8 || f == 9));
    if (o >= 12 && o <= 14)     r.imm = {16'h0000, ins[15:0]};
    else if (o == 15)           r.imm = {16'h0000, ins[15:0]} * 32'd65536;
    else if (ins[15])           r.imm = 32'hFFFF0000 | {16'h0000, ins[15:0]};
    else                        r.imm = {16'h0000, ins[15:0]};
    dst = -1;
    if (o == 0 && f != 8)                        dst = int'(ins[15:11]);
    else if ((o >= 8 && o <= 15) || r.ld)        dst = int'(ins[20:16]);
    else if (o == 3)                             dst = 31;
    r.rw = (dst > 0);
    r.wb = r.rw ? 5'(dst) : 5'd0;
    return r;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] ins, input bit iv);
    ref_t h;
    int o, rs, rt;
    bit rd_s, rd_t;
    if (!m_valid || !iv) return 1'b0;
    h  = ref_dec(m_instr);
    o  = int'(ins[31:26]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd_s = !(o == 2 || o == 3);
    rd_t = (o == 0) || (o >= 40 && o <= 43) || o == 4 || o == 5;
    if (!(h.ld && h.rw) || h.wb == 0) return 1'b0;
    return (rd_s && rs == int'(h.wb)) || (rd_t && rt == int'(h.wb));
  endfunction

  task automatic check_outputs(input string tag);
    ref_t e;
    check({tag, ".out_valid"}, out_valid, m_valid);
    if (m_valid) begin
      e = ref_dec(m_instr);
      check({tag, ".pc"},    out_pc,    m_pc);
      check({tag, ".op"},    op,        m_instr[31:26]);
      check({tag, ".func"},  func,      m_instr[5:0]);
      check({tag, ".regs"},  {reg_s, reg_t, reg_d, shamt},
                             {m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[10:6]});
      check({tag, ".jaddr"}, jump_addr, m_instr[25:0]);
      check({tag, ".imm"},   imm_ext,   e.imm);
      check({tag, ".class"}, {is_rtype, is_load, is_store, is_branch, is_jump},
                             {e.rt, e.ld, e.st, e.br, e.jp});
      check({tag, ".wb"},    {reg_write, wb_reg}, {e.rw, e.wb});
    end
  endtask

  // One clock cycle: drive, check handshake, clock, update model, check outputs.
  task automatic step(input string tag, input bit iv, input logic [31:0] ins,
                      input logic [31:0] pc, input bit ordy, input bit fl);
    bit exp_hz, exp_rdy;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_hz  = ref_hazard(ins, iv);
    exp_rdy = fl || ((!m_valid || ordy) && !exp_hz);
    last_hazard = hazard;
    check({tag, ".hazard"},   hazard,   exp_hz);
    check({tag, ".in_ready"}, in_ready, exp_rdy);
    @(posedge clk);
    if (fl)                    m_valid = 1'b0;
    else if (iv && exp_rdy)    begin m_valid = 1'b1; m_instr = ins; m_pc = pc; end
    else if (m_valid && ordy)  m_valid = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] o;
    logic [5:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: o = 6'h00;
      1: o = 6'(32 + $urandom_range(0, 5));
      2: o = 6'(40 + $urandom_range(0, 3));
      3: o = 6'(8 + $urandom_range(0, 7));
      4: o = 6'(1 + $urandom_range(0, 6));
      5: return $urandom();
      default: o = 6'($urandom_range(0, 63));
    endcase
    f = (sel == 0 && $urandom_range(0, 3) == 0) ? 6'(8 + $urandom_range(0, 1))
                                                : 6'($urandom_range(0, 63));
    return {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom()), f};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    m_valid = 1'b0; m_instr = '0; m_pc = '0; last_hazard = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.bundle", {out_pc, imm_ext, op, func, wb_reg, reg_write, is_rtype, is_load, is_jump},
                          '0);
    @(negedge clk); rst_n = 1'b1;

    // addi $8,$0,-1
    step("addi", 1, 32'h2008FFFF, 32'h100, 1, 0);
    check("addi.imm", imm_ext, 32'hFFFFFFFF);
    check("addi.wb", {reg_write, wb_reg}, {1'b1, 5'd8});
    // ori then lui back-to-back
    step("ori", 1, 32'h3508FFFF, 32'h104, 1, 0);
    check("ori.imm", imm_ext, 32'h0000FFFF);
    step("lui", 1, 32'h3C081234, 32'h108, 1, 0);
    check("lui.imm", imm_ext, 32'h12340000);
    // lw $9,0($8) then dependent add $10,$9,$9
    step("lw", 1, 32'h8D090000, 32'h10C, 1, 0);
    step("add_stall", 1, 32'h01295020, 32'h110, 1, 0);
    check("lu.hazard_seen", last_hazard, 1'b1);
    check("lu.bubble", out_valid, 1'b0);
    step("add_go", 1, 32'h01295020, 32'h110, 1, 0);
    check("lu.add_out", {out_valid, reg_d, out_pc}, {1'b1, 5'd10, 32'h110});
    // backpressure: hold three cycles, then release
    for (int i = 0; i < 3; i++) step("hold", 1, 32'h012A5822, 32'h114, 0, 0);
    check("hold.pc", out_pc, 32'h110);
    step("release", 1, 32'h012A5822, 32'h114, 1, 0);
    check("release.pc", out_pc, 32'h114);
    // flush with bundle held and an instruction offered
    step("hold2", 1, 32'h20010005, 32'h118, 0, 0);
    step("flush", 1, 32'h20010005, 32'h118, 0, 1);
    check("flush.out_valid", out_valid, 1'b0);
    step("idle", 0, 32'h0, 32'h0, 1, 0);
    // jal, then async reset while held
    step("jal", 1, 32'h0C000010, 32'h200, 1, 0);
    check("jal.ctl", {is_jump, reg_write, wb_reg, jump_addr}, {1'b1, 1'b1, 5'd31, 26'h0000010});
    step("jal_hold", 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk); #2;
    rst_n = 1'b0; m_valid = 1'b0;
    #1;
    check("async_reset.out_valid", out_valid, 1'b0);
    check("async_reset.bundle", {out_pc, jump_addr, wb_reg}, '0);
    @(negedge clk); rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++)
      step("rand", ($urandom_range(0, 9) < 7), rand_instr(), $urandom(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
